// File: rtl/pipe_pkg.sv
// Shared constants for the issue scoreboard.
// Parameter defaults and named pipeline latencies.
package pipe_pkg;

  localparam int REG_CNT_DEF = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int LAT_W_DEF   = 3;
  localparam int FWD_MAX_DEF = 2;

  localparam int LAT_ALU  = 2;
  localparam int LAT_LOAD = 3;

endpackage

// File: rtl/sb_counter.sv
// Per-register writeback countdown.
// Load has priority over decrement; floors at zero.
module sb_counter
  import pipe_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [LAT_W-1:0] lat_i,
  output logic [LAT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [LAT_W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= lat_i;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign cnt_o  = r_cnt;
  assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/pipe_scoreboard.sv
// Register scoreboard: hazard stall, forward select
// and in-flight write population for an in-order issue.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_CNT = REG_CNT_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LAT_W   = LAT_W_DEF,
  parameter int FWD_MAX = FWD_MAX_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_rs_i,
  input  logic [ADDR_W-1:0] issue_rt_i,
  input  logic              issue_use_rt_i,
  input  logic              issue_we_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  input  logic [LAT_W-1:0]  issue_lat_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [LAT_W-1:0]  fwd_a_o,
  output logic [LAT_W-1:0]  fwd_b_o,
  output logic [ADDR_W:0]   pend_cnt_o
);

  localparam logic [LAT_W-1:0] FWD_LIM = LAT_W'(FWD_MAX);

  logic [LAT_W-1:0]   w_cnt [REG_CNT];
  logic [REG_CNT-1:1] w_zero;
  logic [REG_CNT-1:1] w_load;
  logic [REG_CNT-1:1] w_nz_nxt;
  logic [LAT_W-1:0]   w_cs;
  logic [LAT_W-1:0]   w_ct;
  logic [LAT_W-1:0]   w_cd;
  logic               w_rd_nz;
  logic               w_haz_a;
  logic               w_haz_b;
  logic               w_waw;
  logic               w_stall;
  logic               w_accept;
  logic [ADDR_W:0]    w_pop;
  logic [ADDR_W:0]    r_pend;

  assign w_cnt[0] = '0;

  generate
    for (genvar g = 1; g < REG_CNT; g++) begin : g_cnt
      assign w_load[g] = w_accept &
                         (issue_rd_i == ADDR_W'(g));
      sb_counter #(
        .LAT_W (LAT_W)
      ) u_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (w_load[g]),
        .lat_i  (issue_lat_i),
        .cnt_o  (w_cnt[g]),
        .zero_o (w_zero[g])
      );
      // Nonzero after the edge: fresh load, or still above one.
      assign w_nz_nxt[g] = w_load[g] |
                           (~w_zero[g] &
                            (w_cnt[g] != LAT_W'(1)));
    end
  endgenerate

  // Sources read pre-issue counts, so no self-forwarding.
  assign w_cs    = w_cnt[issue_rs_i];
  assign w_ct    = w_cnt[issue_rt_i];
  assign w_cd    = w_cnt[issue_rd_i];
  assign w_rd_nz = (issue_rd_i != '0);

  assign w_haz_a = (w_cs > FWD_LIM);
  assign w_haz_b = issue_use_rt_i & (w_ct > FWD_LIM);
  assign w_waw   = issue_we_i & w_rd_nz &
                   (w_cd > issue_lat_i);
  assign w_stall = issue_valid_i &
                   (w_haz_a | w_haz_b | w_waw);

  assign w_accept = issue_valid_i & ~w_stall &
                    ~flush_i & issue_we_i & w_rd_nz &
                    (issue_lat_i != '0);

  always_comb begin
    w_pop = '0;
    for (int r = 1; r < REG_CNT; r++) begin
      w_pop = w_pop + (ADDR_W+1)'(w_nz_nxt[r]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pop;
    end
  end

  assign stall_o    = w_stall;
  assign fwd_a_o    = (w_cs != '0 && !w_haz_a)
                      ? w_cs : '0;
  assign fwd_b_o    = (issue_use_rt_i && w_ct != '0 &&
                       w_ct <= FWD_LIM) ? w_ct : '0;
  assign pend_cnt_o = r_pend;

endmodule
